// File: rtl/mic1_pkg.sv
// mic1_pkg
// Shared definitions for the stalling MIC-1 core: microinstruction field
// positions, B-bus source codes, C-bus destination bit indices, ALU function
// codes and the run/halt state encoding.
//
// Microinstruction layout (LSB first):
//   [3:0] B, [6:4] MEM, [15:7] C, [21:16] ALU, [23:22] SH, [26:24] JAM,
//   [MPC_W+26:27] ADDR.  Only the ADDR width depends on MPC_W.
package mic1_pkg;

    // Field positions.
    localparam int B_LSB     = 0;
    localparam int B_W       = 4;
    localparam int MEM_FETCH = 4;
    localparam int MEM_READ  = 5;
    localparam int MEM_WRITE = 6;
    localparam int C_LSB     = 7;
    localparam int C_W       = 9;
    localparam int ALU_INC   = 16;
    localparam int ALU_INVA  = 17;
    localparam int ALU_ENB   = 18;
    localparam int ALU_ENA   = 19;
    localparam int ALU_F_LSB = 20;   // F = {F0, F1} = mir[21:20]
    localparam int SH_SRA1   = 22;
    localparam int SH_SLL8   = 23;
    localparam int JAM_Z     = 24;
    localparam int JAM_N     = 25;
    localparam int JAM_C     = 26;
    localparam int JAM_LSB   = 24;
    localparam int ADDR_LSB  = 27;

    // Total microinstruction width for a given control-store address width.
    function automatic int mir_width(input int mpc_w);
        return mpc_w + ADDR_LSB;
    endfunction

    // Bit index of each destination inside the C field.
    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;

    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,   // sign-extended
        B_MBRU = 4'd3,   // zero-extended
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } b_sel_e;

    typedef enum logic [1:0] {
        ALU_AND  = 2'b00,
        ALU_OR   = 2'b01,
        ALU_NOTB = 2'b10,
        ALU_ADD  = 2'b11
    } alu_f_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/mic1_alu_shifter.sv
// mic1_alu_shifter
// Combinational MIC-1 ALU followed by the shifter.
// Ports:
//   a_in, b_in   : A operand (H) and B-bus operand
//   ena/enb/inva/inc/f : ALU control bits from the microinstruction
//   sll8, sra1   : shifter controls (SLL8 applied before SRA1)
//   c_bus        : shifted result driven onto the C bus
//   n_flag/z_flag: sign / zero of the ALU result before shifting
module mic1_alu_shifter
    import mic1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              ena,
    input  logic              enb,
    input  logic              inva,
    input  logic              inc,
    input  logic [1:0]        f,
    input  logic              sll8,
    input  logic              sra1,
    output logic [DATA_W-1:0] c_bus,
    output logic              n_flag,
    output logic              z_flag
);

    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] shl_res;

    always_comb begin
        a_op = ena ? a_in : '0;
        if (inva) begin
            a_op = ~a_op;
        end
        b_op = enb ? b_in : '0;

        alu_res = '0;
        case (f)
            ALU_AND:  alu_res = a_op & b_op;
            ALU_OR:   alu_res = a_op | b_op;
            ALU_NOTB: alu_res = ~b_op;
            ALU_ADD:  alu_res = a_op + b_op + {{(DATA_W-1){1'b0}}, inc};
            default:  alu_res = '0;
        endcase

        // Left shift first so that SLL8+SRA1 together yields a net x128
        // with the sign taken from the post-SLL8 value.
        shl_res = sll8 ? {alu_res[DATA_W-9:0], 8'h00} : alu_res;
        c_bus   = sra1 ? {shl_res[DATA_W-1], shl_res[DATA_W-1:1]} : shl_res;
    end

    assign n_flag = alu_res[DATA_W-1];
    assign z_flag = (alu_res == '0);

endmodule

// File: rtl/mic1_stall_core.sv
// mic1_stall_core
// MIC-1 microarchitecture with valid/ready memories and global stall.
// A microinstruction commits only when every outstanding memory operation
// completes in the current cycle; otherwise all architectural state holds.
// Ports:
//   clk, resetn         : clock, synchronous active-low reset
//   mp_addr / mp_rdata  : control-store address (MPC) and microinstruction
//   dmem_*              : data memory port (MAR word address, MDR data)
//   imem_*              : opcode fetch port (PC byte address, MBR byte)
//   halted              : core has committed the halt microinstruction
//   retired             : committed microinstruction count
module mic1_stall_core
    import mic1_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          MPC_W     = 9,
    parameter logic [31:0] CPP_RESET = 32'h0000_4000
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic [MPC_W-1:0]          mp_addr,
    input  logic [MPC_W+ADDR_LSB-1:0] mp_rdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wdata,
    input  logic                      dmem_ready,
    input  logic [DATA_W-1:0]         dmem_rdata,
    output logic                      imem_req,
    output logic [DATA_W-1:0]         imem_addr,
    input  logic                      imem_ready,
    input  logic [7:0]                imem_rdata,
    output logic                      halted,
    output logic [DATA_W-1:0]         retired
);

    logic [MPC_W-1:0]  mpc_q, mpc_d;
    logic [DATA_W-1:0] mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d;
    logic [DATA_W-1:0] sp_q, sp_d, lv_q, lv_d, cpp_q, cpp_d;
    logic [DATA_W-1:0] tos_q, tos_d, opc_q, opc_d, h_q, h_d;
    logic [DATA_W-1:0] retired_q, retired_d;
    logic [7:0]        mbr_q, mbr_d;
    logic              rd_p_q, rd_p_d, wr_p_q, wr_p_d, f_p_q, f_p_d;
    state_e            state_q, state_d;

    // Microinstruction decode.
    b_sel_e            b_sel;
    logic [C_W-1:0]    c_en;
    logic [2:0]        jam;
    logic [MPC_W-1:0]  addr_field;

    assign b_sel      = b_sel_e'(mp_rdata[B_LSB +: B_W]);
    assign c_en       = mp_rdata[C_LSB +: C_W];
    assign jam        = mp_rdata[JAM_LSB +: 3];
    assign addr_field = mp_rdata[ADDR_LSB +: MPC_W];

    logic [DATA_W-1:0] b_bus;
    logic [DATA_W-1:0] c_bus;
    logic              n_flag, z_flag;

    always_comb begin
        b_bus = '0;
        case (b_sel)
            B_MDR:   b_bus = mdr_q;
            B_PC:    b_bus = pc_q;
            B_MBR:   b_bus = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
            B_MBRU:  b_bus = {{(DATA_W-8){1'b0}}, mbr_q};
            B_SP:    b_bus = sp_q;
            B_LV:    b_bus = lv_q;
            B_CPP:   b_bus = cpp_q;
            B_TOS:   b_bus = tos_q;
            B_OPC:   b_bus = opc_q;
            default: b_bus = '0;
        endcase
    end

    mic1_alu_shifter #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_in   (h_q),
        .b_in   (b_bus),
        .ena    (mp_rdata[ALU_ENA]),
        .enb    (mp_rdata[ALU_ENB]),
        .inva   (mp_rdata[ALU_INVA]),
        .inc    (mp_rdata[ALU_INC]),
        .f      (mp_rdata[ALU_F_LSB +: 2]),
        .sll8   (mp_rdata[SH_SLL8]),
        .sra1   (mp_rdata[SH_SRA1]),
        .c_bus  (c_bus),
        .n_flag (n_flag),
        .z_flag (z_flag)
    );

    logic [MPC_W-1:0] next_mpc;
    logic             halt_hit;
    logic             commit;

    always_comb begin
        if (mp_rdata[JAM_C]) begin
            next_mpc = addr_field | {{(MPC_W-8){1'b0}}, mbr_q};
        end else begin
            next_mpc = {addr_field[MPC_W-1] | (mp_rdata[JAM_Z] & z_flag)
                                            | (mp_rdata[JAM_N] & n_flag),
                        addr_field[MPC_W-2:0]};
        end
    end

    assign halt_hit = (addr_field == {MPC_W{1'b1}}) && (jam == 3'b000);
    assign commit   = (state_q == ST_RUN) && !(dmem_req && !dmem_ready)
                                          && !(f_p_q && !imem_ready);

    always_comb begin
        mpc_d     = mpc_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        lv_d      = lv_q;
        cpp_d     = cpp_q;
        tos_d     = tos_q;
        opc_d     = opc_q;
        h_d       = h_q;
        mbr_d     = mbr_q;
        retired_d = retired_q;
        rd_p_d    = rd_p_q;
        wr_p_d    = wr_p_q;
        f_p_d     = f_p_q;
        state_d   = state_q;

        // Completion clears the matching flags; a same-cycle commit below
        // reloads them from the new microinstruction.
        if (dmem_ready) begin
            rd_p_d = 1'b0;
            wr_p_d = 1'b0;
        end
        if (imem_ready) begin
            f_p_d = 1'b0;
        end

        if (commit) begin
            if (c_en[C_MAR]) mar_d = c_bus;
            if (c_en[C_MDR]) mdr_d = c_bus;
            if (c_en[C_PC])  pc_d  = c_bus;
            if (c_en[C_SP])  sp_d  = c_bus;
            if (c_en[C_LV])  lv_d  = c_bus;
            if (c_en[C_CPP]) cpp_d = c_bus;
            if (c_en[C_TOS]) tos_d = c_bus;
            if (c_en[C_OPC]) opc_d = c_bus;
            if (c_en[C_H])   h_d   = c_bus;
            // A combined read+write request performs only the write.
            rd_p_d    = mp_rdata[MEM_READ] & ~mp_rdata[MEM_WRITE];
            wr_p_d    = mp_rdata[MEM_WRITE];
            f_p_d     = mp_rdata[MEM_FETCH];
            mpc_d     = next_mpc;
            retired_d = retired_q + DATA_W'(1);
            if (halt_hit) begin
                state_d = ST_HALT;
            end
        end

        // Landing data overrides a same-cycle C-bus write to MDR.
        if (rd_p_q && !wr_p_q && dmem_ready) begin
            mdr_d = dmem_rdata;
        end
        if (f_p_q && imem_ready) begin
            mbr_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mpc_q     <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            pc_q      <= '1;
            sp_q      <= '0;
            lv_q      <= '0;
            cpp_q     <= DATA_W'(CPP_RESET);
            tos_q     <= '0;
            opc_q     <= '0;
            h_q       <= '0;
            mbr_q     <= '0;
            retired_q <= '0;
            rd_p_q    <= 1'b0;
            wr_p_q    <= 1'b0;
            f_p_q     <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            mpc_q     <= mpc_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            lv_q      <= lv_d;
            cpp_q     <= cpp_d;
            tos_q     <= tos_d;
            opc_q     <= opc_d;
            h_q       <= h_d;
            mbr_q     <= mbr_d;
            retired_q <= retired_d;
            rd_p_q    <= rd_p_d;
            wr_p_q    <= wr_p_d;
            f_p_q     <= f_p_d;
            state_q   <= state_d;
        end
    end

    assign mp_addr    = mpc_q;
    assign dmem_req   = rd_p_q | wr_p_q;
    assign dmem_we    = wr_p_q;
    assign dmem_addr  = mar_q;
    assign dmem_wdata = mdr_q;
    assign imem_req   = f_p_q;
    assign imem_addr  = pc_q;
    assign halted     = (state_q == ST_HALT);
    assign retired    = retired_q;

endmodule
